int_rs_age: RTL and testbench
=============================

# int_rs_age

Parametrised integer reservation station with age-ordered (oldest-ready-first) selection for the out-of-order backend. It sits between dispatch and an integer functional unit. It holds renamed uops until their source physical registers are produced, then issues them over a valid/ready handshake, so the FU can apply backpressure. Over the first-generation station it adds configurable depth, CDB lane count and payload width, oldest-first issue, issue backpressure, pipeline flush and an occupancy count.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two not required, ≥2)
- CDB_WIDTH, 2, number of CDB writeback lanes snooped
- PRF_IDX, 6, physical register index width
- PAYLOAD_W, 64, opaque uop payload width (rob_id, rd_phy, opcode, imm, pc …), passed through untouched

Ports:
- Clocking: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries (branch mispredict / exception)
- ds_valid  in  1  dispatch offers a uop
- ds_ready  out  1  at least one free entry
- ds_src1_used, ds_src2_used  in  1 each  operand actually reads rs1/rs2 (0 = zero/imm operand)
- ds_rs1_phy, ds_rs2_phy  in  PRF_IDX each  source physical registers
- ds_rs1_rdy, ds_rs2_rdy  in  1 each  source already valid in PRF at dispatch
- ds_payload  in  PAYLOAD_W  uop payload
- cdb_valid  in  CDB_WIDTH  per-lane writeback valid
- cdb_rd_phy  in  CDB_WIDTH*PRF_IDX  per-lane destination, lane k at [k*PRF_IDX +: PRF_IDX]
- iss_valid  out  1  selected entry ready to issue
- iss_ready  in  1  FU accepts
- iss_rs1_phy, iss_rs2_phy  out  PRF_IDX each  PRF read addresses of the selected entry
- iss_payload  out  PAYLOAD_W  payload of the selected entry
- occupancy  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Entry state: valid, src1_rdy, src2_rdy, rs1_phy, rs2_phy, payload. Age matrix DEPTH×DEPTH: older[i][j]=1 means entry j is older than entry i.
- Push: fires when ds_valid && ds_ready && !flush. The uop is written to the lowest-index free entry.
  - srcN_rdy ← !ds_srcN_used | ds_rsN_rdy | (a same-cycle cdb lane is valid with rd_phy == ds_rsN_phy).
  - Age row of the new entry ← current valid vector; its column in every other row is cleared.
- Wakeup: each cycle, for every valid entry and every lane k with cdb_valid[k] and matching rd_phy, the corresponding srcN_rdy is set. Matching uses the full PRF_IDX width with no special case for index 0.
- Ready (combinational): valid && (src1_rdy | src1 hit on any CDB lane this cycle) && (same for src2).
- Select: the ready entry with no older ready entry. Exactly one entry or none is selected.
  - iss_valid = any ready && !flush.
  - iss_* are driven from the selected entry. They are 0 when none is selected.
- Issue: fires on iss_valid && iss_ready. The selected entry's valid is cleared at the next edge.
- iss_valid/iss_payload are not sticky. While iss_ready=0, a newly ready older entry may replace the current selection.
- ds_ready = occupancy < DEPTH, computed from registered state only. A slot freed by an issue this cycle is usable next cycle.
- Flush: all valid bits are cleared at the next edge. Push and issue in the flush cycle are suppressed. Flush has priority over everything.
- occupancy is updated at the next edge: +1 on push, −1 on issue, both or neither gives no change.

## Timing
- Reset: all entries invalid. Age matrix 0. ds_ready=1, iss_valid=0, occupancy=0, iss_* = 0.
- Push in cycle N: earliest iss_valid is cycle N+1.
- CDB hit in cycle N on a stored entry: the entry may issue in cycle N (combinational wakeup bypass).
- Issue in cycle N: the entry is freed, and ds_ready/occupancy are reflected, at N+1.
- Simultaneous push + issue + wakeup in one cycle are all applied. The pushed entry is never selected in its push cycle.
- Reset during any activity: returns to the reset state at the next edge, regardless of flush, ds_valid or iss_ready.

## Test plan
Configuration for all scenarios: DEPTH=4, CDB_WIDTH=2, PRF_IDX=6.

1. Reset, then idle → ds_ready=1, iss_valid=0, occupancy=0.
2. Push A (srcs unused, payload 0x11) in cycle 1, iss_ready=1 → iss_valid=1 with payload 0x11 in cycle 2; occupancy goes 1 → 0 at cycle 3.
3. Push B (rs1_phy=7, not rdy) then C (rs1_phy=7, not rdy); cdb lane1 rd 7 → B issues that cycle (older), C issues the next cycle.
4. Push D (rs2_phy=9, not rdy) in the same cycle that cdb lane0 carries rd 9 → D issues the next cycle, with no further CDB needed.
5. Four pushes with unready sources → occupancy=4, ds_ready=0, and a fifth ds_valid is ignored. Wake and issue one entry → ds_ready=1 the following cycle. Holding iss_ready=0 for 3 cycles keeps occupancy=4 and iss_valid=1.
6. With 3 entries, assert flush together with ds_valid=1 and iss_ready=1 → iss_valid=0 that cycle; next cycle occupancy=0, ds_ready=1, and no issue occurred.

Source files
------------

// File: rtl/int_rs_age.sv
// Integer reservation station with age-matrix, oldest-ready-first issue.
// Entries wake up from the CDB lanes. A same-cycle CDB hit also bypasses straight into the issue decision.
module int_rs_age #(
  parameter int DEPTH     = 8,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX   = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          ds_valid,
  output logic                          ds_ready,
  input  logic                          ds_src1_used,
  input  logic                          ds_src2_used,
  input  logic [PRF_IDX-1:0]            ds_rs1_phy,
  input  logic [PRF_IDX-1:0]            ds_rs2_phy,
  input  logic                          ds_rs1_rdy,
  input  logic                          ds_rs2_rdy,
  input  logic [PAYLOAD_W-1:0]          ds_payload,
  input  logic [CDB_WIDTH-1:0]          cdb_valid,
  input  logic [CDB_WIDTH*PRF_IDX-1:0]  cdb_rd_phy,
  output logic                          iss_valid,
  input  logic                          iss_ready,
  output logic [PRF_IDX-1:0]            iss_rs1_phy,
  output logic [PRF_IDX-1:0]            iss_rs2_phy,
  output logic [PAYLOAD_W-1:0]          iss_payload,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     valid_q, s1_rdy_q, s2_rdy_q;
  logic [PRF_IDX-1:0]   rs1_q [DEPTH];
  logic [PRF_IDX-1:0]   rs2_q [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q  [DEPTH];
  logic [DEPTH-1:0]     older_q [DEPTH];
  logic [OCC_W-1:0]     occ_q;

  logic [DEPTH-1:0] hit1, hit2, rdy, sel;
  logic             ds_hit1, ds_hit2;
  logic [IDX_W-1:0] free_idx;
  logic             push, issue;

  always_comb begin
    hit1    = '0;
    hit2    = '0;
    ds_hit1 = 1'b0;
    ds_hit2 = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (cdb_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == rs1_q[i]) hit1[i] = 1'b1;
          if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == rs2_q[i]) hit2[i] = 1'b1;
        end
        if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == ds_rs1_phy) ds_hit1 = 1'b1;
        if (cdb_rd_phy[k*PRF_IDX +: PRF_IDX] == ds_rs2_phy) ds_hit2 = 1'b1;
      end
    end
  end

  assign rdy = valid_q & (s1_rdy_q | hit1) & (s2_rdy_q | hit2);

  // An entry is picked only when no older entry is also ready, so sel is one-hot or empty.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++)
      sel[i] = rdy[i] && ((older_q[i] & rdy) == '0);
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    iss_payload = '0;
    iss_rs1_phy = '0;
    iss_rs2_phy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        iss_payload = iss_payload | pl_q[i];
        iss_rs1_phy = iss_rs1_phy | rs1_q[i];
        iss_rs2_phy = iss_rs2_phy | rs2_q[i];
      end
    end
  end

  assign ds_ready  = occ_q < OCC_W'(DEPTH);
  assign iss_valid = (|rdy) && !flush;
  assign occupancy = occ_q;
  assign push      = ds_valid && ds_ready && !flush;
  assign issue     = iss_valid && iss_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && hit1[i]) s1_rdy_q[i] <= 1'b1;
        if (valid_q[i] && hit2[i]) s2_rdy_q[i] <= 1'b1;
      end
      valid_q <= issue ? (valid_q & ~sel) : valid_q;
      if (push) begin
        valid_q[free_idx]  <= 1'b1;
        s1_rdy_q[free_idx] <= !ds_src1_used || ds_rs1_rdy || ds_hit1;
        s2_rdy_q[free_idx] <= !ds_src2_used || ds_rs2_rdy || ds_hit2;
        rs1_q[free_idx]    <= ds_rs1_phy;
        rs2_q[free_idx]    <= ds_rs2_phy;
        pl_q[free_idx]     <= ds_payload;
        // Row write comes last so it wins over the column clear on the same row.
        for (int r = 0; r < DEPTH; r++) older_q[r][free_idx] <= 1'b0;
        older_q[free_idx] <= valid_q;
      end
      case ({push, issue})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_int_rs_age.sv
// Bench for int_rs_age: directed vector table followed by random traffic checked
// against an age-ordered queue model.
module tb_int_rs_age;
  localparam int DEPTH = 4, CW = 2, PW = 6, PLW = 16;

  logic           clk = 1'b0;
  logic           rst, flush, ds_valid, ds_ready;
  logic           u1, u2, r1, r2;
  logic [PW-1:0]  p1, p2, c0, c1;
  logic [PLW-1:0] ds_payload, iss_payload;
  logic [CW-1:0]  cdb_valid;
  logic [CW*PW-1:0] cdb_rd_phy;
  logic           iss_valid, iss_ready;
  logic [PW-1:0]  iss_rs1_phy, iss_rs2_phy;
  logic [2:0]     occupancy;

  always #5 clk = ~clk;
  assign cdb_rd_phy = {c1, c0};

  int_rs_age #(.DEPTH(DEPTH), .CDB_WIDTH(CW), .PRF_IDX(PW), .PAYLOAD_W(PLW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ds_valid(ds_valid), .ds_ready(ds_ready),
    .ds_src1_used(u1), .ds_src2_used(u2), .ds_rs1_phy(p1), .ds_rs2_phy(p2),
    .ds_rs1_rdy(r1), .ds_rs2_rdy(r2), .ds_payload(ds_payload),
    .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1_phy(iss_rs1_phy),
    .iss_rs2_phy(iss_rs2_phy), .iss_payload(iss_payload), .occupancy(occupancy)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic fl, dv, u1; logic [5:0] p1; logic u2; logic [5:0] p2; logic [15:0] pl;
    logic [1:0] cv; logic [5:0] c0, c1; logic ir;
    logic e_dsr, e_iv; logic [2:0] e_occ; logic [15:0] e_pl; logic cp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic fl, input logic dv, input logic uu1, input logic [5:0] pp1,
                              input logic uu2, input logic [5:0] pp2, input logic [15:0] pl,
                              input logic [1:0] cv, input logic [5:0] cc0, input logic [5:0] cc1,
                              input logic ir, input logic e_dsr, input logic e_iv,
                              input logic [2:0] e_occ, input logic [15:0] e_pl, input logic cp);
    vec_t v;
    v.fl = fl; v.dv = dv; v.u1 = uu1; v.p1 = pp1; v.u2 = uu2; v.p2 = pp2; v.pl = pl;
    v.cv = cv; v.c0 = cc0; v.c1 = cc1; v.ir = ir;
    v.e_dsr = e_dsr; v.e_iv = e_iv; v.e_occ = e_occ; v.e_pl = e_pl; v.cp = cp;
    return v;
  endfunction

  // Reference model: entries kept in dispatch order, so the first ready one is the oldest.
  typedef struct { logic [5:0] p1, p2; bit r1, r2; logic [15:0] pl; } ent_t;
  ent_t q[$];

  function automatic bit hit(input logic [5:0] p);
    return (cdb_valid[0] && c0 == p) || (cdb_valid[1] && c1 == p);
  endfunction

  function automatic int find_sel();
    for (int i = 0; i < q.size(); i++)
      if ((q[i].r1 || hit(q[i].p1)) && (q[i].r2 || hit(q[i].p2))) return i;
    return -1;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; ds_valid = 1'b0; u1 = 1'b0; u2 = 1'b0; r1 = 1'b0; r2 = 1'b0;
    p1 = '0; p2 = '0; c0 = '0; c1 = '0; cdb_valid = '0; ds_payload = '0; iss_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //        fl dv u1 p1 u2 p2 pl     cv     c0 c1 ir  dsr iv occ pl    cp
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 0,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 'h11, 2'b00, 0, 0, 1,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 1, 1, 'h11, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 1, 1, 7, 0, 0, 'h22, 2'b00, 0, 0, 1,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 1, 1, 7, 0, 0, 'h33, 2'b00, 0, 0, 1,  1, 0, 1, 'h00, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b10, 0, 7, 1,  1, 1, 2, 'h22, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 1, 1, 'h33, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 9, 'h44, 2'b01, 9, 0, 1,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 1, 1, 'h44, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 1, 1, 10, 0, 0, 'h51, 2'b00, 0, 0, 0, 1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 1, 1, 11, 0, 0, 'h52, 2'b00, 0, 0, 0, 1, 0, 1, 'h00, 1));
    tbl.push_back(mk(0, 1, 1, 12, 0, 0, 'h53, 2'b00, 0, 0, 0, 1, 0, 2, 'h00, 1));
    tbl.push_back(mk(0, 1, 1, 13, 0, 0, 'h54, 2'b00, 0, 0, 0, 1, 0, 3, 'h00, 1));
    tbl.push_back(mk(0, 1, 1, 14, 0, 0, 'h55, 2'b00, 0, 0, 0, 0, 0, 4, 'h00, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b01, 12, 0, 0, 0, 1, 4, 'h53, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b01, 10, 0, 0, 0, 1, 4, 'h51, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 0,  0, 1, 4, 'h51, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  0, 1, 4, 'h51, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 0,  1, 1, 3, 'h53, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 'h66, 2'b00, 0, 0, 1,  1, 0, 3, 'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 'h77, 2'b00, 0, 0, 1,  1, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 1, 1, 'h77, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h00, 2'b00, 0, 0, 1,  1, 0, 0, 'h00, 1));

    for (int n = 0; n < tbl.size(); n++) begin
      flush = tbl[n].fl; ds_valid = tbl[n].dv; u1 = tbl[n].u1; p1 = tbl[n].p1;
      u2 = tbl[n].u2; p2 = tbl[n].p2; r1 = 1'b0; r2 = 1'b0; ds_payload = tbl[n].pl;
      cdb_valid = tbl[n].cv; c0 = tbl[n].c0; c1 = tbl[n].c1; iss_ready = tbl[n].ir;
      @(negedge clk);
      chk($sformatf("vec%0d ds_ready", n), 32'(ds_ready), 32'(tbl[n].e_dsr));
      chk($sformatf("vec%0d iss_valid", n), 32'(iss_valid), 32'(tbl[n].e_iv));
      chk($sformatf("vec%0d occupancy", n), 32'(occupancy), 32'(tbl[n].e_occ));
      if (tbl[n].cp) chk($sformatf("vec%0d iss_payload", n), 32'(iss_payload), 32'(tbl[n].e_pl));
      @(posedge clk);
      #1;
    end

    // Random traffic, starting from a fresh reset so the model and DUT agree.
    rst = 1'b1; flush = 1'b0; ds_valid = 1'b0; cdb_valid = '0; iss_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      int   s;
      bit   e_iv, psh, iss;
      ent_t ne;
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 99) < 3);
      ds_valid   = ($urandom_range(0, 9) < 6);
      u1         = ($urandom_range(0, 3) != 0);
      u2         = ($urandom_range(0, 3) != 0);
      r1         = ($urandom_range(0, 3) == 0);
      r2         = ($urandom_range(0, 3) == 0);
      p1         = 6'($urandom_range(0, 7));
      p2         = 6'($urandom_range(0, 7));
      ds_payload = 16'($urandom);
      cdb_valid  = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
      c0         = 6'($urandom_range(0, 7));
      c1         = 6'($urandom_range(0, 7));
      iss_ready  = ($urandom_range(0, 1) == 1);

      s    = find_sel();
      e_iv = (s >= 0) && !flush;
      @(negedge clk);
      chk("rnd iss_valid", 32'(iss_valid), 32'(e_iv));
      chk("rnd ds_ready", 32'(ds_ready), 32'(q.size() < DEPTH));
      chk("rnd occupancy", 32'(occupancy), 32'(q.size()));
      chk("rnd iss_payload", 32'(iss_payload), (s >= 0) ? 32'(q[s].pl) : 32'd0);
      chk("rnd iss_rs1_phy", 32'(iss_rs1_phy), (s >= 0) ? 32'(q[s].p1) : 32'd0);
      chk("rnd iss_rs2_phy", 32'(iss_rs2_phy), (s >= 0) ? 32'(q[s].p2) : 32'd0);

      if (rst || flush) begin
        q.delete();
      end else begin
        psh   = ds_valid && (q.size() < DEPTH);
        iss   = e_iv && iss_ready;
        ne.p1 = p1; ne.p2 = p2; ne.pl = ds_payload;
        ne.r1 = !u1 || r1 || hit(p1);
        ne.r2 = !u2 || r2 || hit(p2);
        for (int i = 0; i < q.size(); i++) begin
          if (hit(q[i].p1)) q[i].r1 = 1'b1;
          if (hit(q[i].p2)) q[i].r2 = 1'b1;
        end
        if (iss) q.delete(s);
        if (psh) q.push_back(ne);
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
